// File: rtl/bist_pkg.sv
// Shared definitions for the memory BIST sequencer: element codes, FSM states
// and the March C- element tables (direction, op count, op kind and polarity).
package bist_pkg;

    localparam logic [2:0] M0 = 3'd0;
    localparam logic [2:0] M1 = 3'd1;
    localparam logic [2:0] M2 = 3'd2;
    localparam logic [2:0] M3 = 3'd3;
    localparam logic [2:0] M4 = 3'd4;
    localparam logic [2:0] M5 = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ascending address order for every element except the two descending ones.
    function automatic logic elem_dir_up(input logic [2:0] elem);
        return !((elem == M3) || (elem == M4));
    endfunction

    // M0 and M5 carry a single op per address, the others a read/write pair.
    function automatic logic elem_last_op(input logic [2:0] elem, input logic op);
        return ((elem == M0) || (elem == M5)) ? 1'b1 : op;
    endfunction

    // Within the paired elements the read always comes first.
    function automatic logic elem_op_is_read(input logic [2:0] elem, input logic op);
        case (elem)
            M0:      return 1'b0;
            M5:      return 1'b1;
            default: return !op;
        endcase
    endfunction

    // Polarity written, or expected on a read, for each element/op.
    function automatic logic elem_op_data(input logic [2:0] elem, input logic op);
        case (elem)
            M1, M3:  return op;
            M2, M4:  return !op;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/address_generator.sv
// Up/down address counter with load-zero and load-max controls; carry flags
// the terminal address for the current counting direction.
module address_generator #(
    parameter int ad_width = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reset,
    input  logic                preset,
    input  logic                en,
    input  logic                up_down,
    output logic [ad_width-1:0] address,
    output logic                carry
);

    // Address register: loads take priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            address <= '0;
        end else if (reset) begin
            address <= '0;
        end else if (preset) begin
            address <= '1;
        end else if (en) begin
            address <= up_down ? address + 1'b1 : address - 1'b1;
        end
    end

    // Terminal address: N-1 when counting up, 0 when counting down.
    always_comb begin
        carry = up_down ? (address == {ad_width{1'b1}}) : (address == '0);
    end

endmodule

// File: rtl/march_c_controller.sv
// March C- sequencer: issues one read or write per cycle over the whole
// address space, checks reads against the comparator and records the first
// failing address and element.
module march_c_controller
    import bist_pkg::*;
#(
    parameter int ad_width     = 4,
    parameter bit stop_on_fail = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                is_equal,
    output logic                read,
    output logic                write,
    output logic                data,
    output logic [ad_width-1:0] address,
    output logic                busy,
    output logic                done,
    output logic                fail,
    output logic [ad_width-1:0] fail_addr,
    output logic [2:0]          fail_elem
);

    state_t     state;
    state_t     state_next;
    logic [2:0] elem;
    logic       op;

    logic       in_run;
    logic       start_ok;
    logic       op_read;
    logic       last_op;
    logic       last_elem;
    logic       carry;
    logic       miscompare;
    logic       abort;
    logic       finish;
    logic       step;
    logic       elem_wrap;
    logic       next_up;

    logic       ag_reset;
    logic       ag_preset;
    logic       ag_en;
    logic       ag_up_down;

    // Decode of the current element/op and the end-of-element conditions.
    always_comb begin
        in_run     = (state == RUN);
        start_ok   = (state != RUN) && start;
        op_read    = elem_op_is_read(elem, op);
        last_op    = elem_last_op(elem, op);
        last_elem  = (elem == M5);
        miscompare = in_run && op_read && !is_equal;
        abort      = miscompare && stop_on_fail;
        finish     = in_run && last_op && carry && last_elem;
        step       = in_run && !abort;
        elem_wrap  = step && last_op && carry && !last_elem;
        next_up    = elem_dir_up(elem + 3'd1);
    end

    // Address counter controls: step inside an element, reload at element
    // boundaries so the next element starts without a bubble.
    always_comb begin
        ag_up_down = elem_dir_up(elem);
        ag_reset   = start_ok || (elem_wrap && next_up);
        ag_preset  = elem_wrap && !next_up;
        ag_en      = step && last_op && !carry;
    end

    address_generator #(
        .ad_width (ad_width)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .reset   (ag_reset),
        .preset  (ag_preset),
        .en      (ag_en),
        .up_down (ag_up_down),
        .address (address),
        .carry   (carry)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start leaves IDLE/DONE, completion or abort ends RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = RUN;
            RUN:        if (abort || finish) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // Element and op counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            elem <= M0;
            op   <= 1'b0;
        end else if (start_ok) begin
            elem <= M0;
            op   <= 1'b0;
        end else if (step) begin
            if (!last_op) begin
                op <= 1'b1;
            end else begin
                op <= 1'b0;
                if (carry && !last_elem) elem <= elem + 3'd1;
            end
        end
    end

    // Sticky fail flag with capture of the first miscompare only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (start_ok) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
        end else if (miscompare) begin
            fail <= 1'b1;
            if (!fail) begin
                fail_addr <= address;
                fail_elem <= elem;
            end
        end
    end

    // Strobes, polarity and status decoded from the state and element table.
    always_comb begin
        read  = in_run && op_read;
        write = in_run && !op_read;
        data  = in_run && elem_op_data(elem, op);
        busy  = in_run;
        done  = (state == DONE);
    end

endmodule
